// File: rtl/tdm_demux14.sv
// rtl/tdm_demux14.sv - four-channel TDM demultiplexer with frame sync tracking
//
// Purpose: splits one serial time-division sample stream into four registered
// channel outputs. An internal 2-bit channel counter selects the slot, and a
// sync flag on a valid sample marks channel 0. A frame reaches the outputs
// only once its channel-3 sample has arrived.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   din          serial sample stream (WIDTH bits)
//   din_valid    din carries a sample this cycle
//   sync         current valid sample is channel 0
//   out1..out4   channel 0..3 samples of the last completed frame
//   frame_valid  one-cycle pulse, out1..out4 just updated
//   sync_err     one-cycle pulse, sync seen mid-frame
//   locked       high while frame alignment is held
//   chan         channel index of the next accepted sample
module tdm_demux14 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [1:0]       chan
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       chan_q, chan_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic [WIDTH-1:0] out3_q, out3_d, out4_q, out4_d;
  logic             fv_q, fv_d, serr_q, serr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      chan_q  <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      out3_q  <= '0;
      out4_q  <= '0;
      fv_q    <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      out3_q  <= out3_d;
      out4_q  <= out4_d;
      fv_q    <= fv_d;
      serr_q  <= serr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    out1_d  = out1_q;
    out2_d  = out2_q;
    out3_d  = out3_q;
    out4_d  = out4_q;
    fv_d    = 1'b0;
    serr_d  = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          // Unsynchronised samples are dropped until a frame start shows up.
          if (sync) begin
            state_d = LOCKED;
            sh0_d   = din;
            chan_d  = 2'd1;
          end
        end
        LOCKED: begin
          if (sync && (chan_q != 2'd0)) begin
            // Realign: the partial frame is abandoned and this sample opens a new one.
            serr_d = 1'b1;
            sh0_d  = din;
            chan_d = 2'd1;
          end else begin
            unique case (chan_q)
              2'd0: sh0_d = din;
              2'd1: sh1_d = din;
              2'd2: sh2_d = din;
              2'd3: begin
                // Channel 3 bypasses the shadow so all four outputs update together.
                out1_d = sh0_q;
                out2_d = sh1_q;
                out3_d = sh2_q;
                out4_d = din;
                fv_d   = 1'b1;
              end
            endcase
            chan_d = chan_q + 2'd1;
          end
        end
      endcase
    end
  end

  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign out4        = out4_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
  assign locked      = (state_q == LOCKED);
  assign chan        = chan_q;

endmodule

// File: tb/tb_tdm_demux14.sv
// tb/tb_tdm_demux14.sv - directed self-checking bench for tdm_demux14
module tb_tdm_demux14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] din = 2'd0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [1:0] out1, out2, out3, out4;
  logic       frame_valid, sync_err, locked;
  logic [1:0] chan;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int se_cnt = 0;

  tdm_demux14 #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked), .chan(chan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [1:0] d);
    din_valid = v;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
    fv_cnt += int'(frame_valid);
    se_cnt += int'(sync_err);
    check("fv_serr_exclusive", {31'd0, frame_valid & sync_err}, 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 2'd3);
    rst = 1'b0;
    din_valid = 1'b0;
    sync = 1'b0;
    fv_cnt = 0;
    se_cnt = 0;
  endtask

  task automatic check_outs(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, out1, out2, out3, out4}, {24'd0, exp});
  endtask

  initial begin
    // Reset state, with valid+sync held to show reset priority
    do_reset(2);
    check_outs("reset_outs", 8'h00);
    check("reset_locked", {31'd0, locked}, 32'd0);
    check("reset_chan", {30'd0, chan}, 32'd0);
    check("reset_fv", {31'd0, frame_valid}, 32'd0);
    check("reset_serr", {31'd0, sync_err}, 32'd0);

    // Basic frame 00(sync),01,10,11
    step(1, 1, 2'd0);
    check("f1_locked", {31'd0, locked}, 32'd1);
    check("f1_chan1", {30'd0, chan}, 32'd1);
    step(1, 0, 2'd1);
    step(1, 0, 2'd2);
    check("f1_chan3", {30'd0, chan}, 32'd3);
    check("f1_no_early_fv", {31'd0, frame_valid}, 32'd0);
    check_outs("f1_partial_hidden", 8'h00);
    step(1, 0, 2'd3);
    check_outs("f1_outs", 8'b00_01_10_11);
    check("f1_fv", {31'd0, frame_valid}, 32'd1);
    check("f1_chan_wrap", {30'd0, chan}, 32'd0);
    step(0, 0, 2'd0);
    check("f1_fv_one_cycle", {31'd0, frame_valid}, 32'd0);
    check_outs("f1_hold", 8'b00_01_10_11);

    // Hunt discards non-sync samples
    do_reset(1);
    step(1, 0, 2'd3);
    step(1, 0, 2'd3);
    check("hunt_locked", {31'd0, locked}, 32'd0);
    check("hunt_chan", {30'd0, chan}, 32'd0);
    step(1, 1, 2'd0);
    step(1, 0, 2'd1);
    step(1, 0, 2'd2);
    step(1, 0, 2'd3);
    check_outs("hunt_outs", 8'b00_01_10_11);
    check("hunt_fv_cnt", fv_cnt, 32'd1);

    // Mid-frame sync: error, partial frame dropped, realign
    fv_cnt = 0;
    step(1, 1, 2'd1);
    step(1, 0, 2'd2);
    step(1, 1, 2'd3);
    check("serr_pulse", {31'd0, sync_err}, 32'd1);
    check("serr_chan", {30'd0, chan}, 32'd1);
    check("serr_locked", {31'd0, locked}, 32'd1);
    check_outs("serr_outs_held", 8'b00_01_10_11);
    step(1, 0, 2'd0);
    check("serr_one_cycle", {31'd0, sync_err}, 32'd0);
    step(1, 0, 2'd1);
    step(1, 0, 2'd2);
    check_outs("serr_realigned", 8'b11_00_01_10);
    check("serr_fv_cnt", fv_cnt, 32'd1);

    // Gaps inside a frame
    fv_cnt = 0;
    step(1, 1, 2'd2);
    for (int g = 0; g < 3; g++) step(0, 0, 2'd3);
    check("gap_chan_hold", {30'd0, chan}, 32'd1);
    step(1, 0, 2'd1);
    for (int g = 0; g < 3; g++) step(0, 1, 2'd0);
    step(1, 0, 2'd3);
    for (int g = 0; g < 3; g++) step(0, 0, 2'd1);
    check("gap_chan3", {30'd0, chan}, 32'd3);
    check_outs("gap_outs_held", 8'b11_00_01_10);
    step(1, 0, 2'd0);
    for (int g = 0; g < 3; g++) step(0, 0, 2'd2);
    check_outs("gap_outs", 8'b10_01_11_00);
    check("gap_fv_cnt", fv_cnt, 32'd1);

    // Back-to-back frames, free-running alignment on the second
    fv_cnt = 0;
    se_cnt = 0;
    step(1, 1, 2'd0);
    step(1, 0, 2'd1);
    step(1, 0, 2'd2);
    step(1, 0, 2'd3);
    check_outs("b2b_first", 8'b00_01_10_11);
    step(1, 0, 2'd3);
    step(1, 0, 2'd2);
    step(1, 0, 2'd1);
    step(1, 0, 2'd0);
    check_outs("b2b_second", 8'b11_10_01_00);
    check("b2b_fv_cnt", fv_cnt, 32'd2);
    check("b2b_no_serr", se_cnt, 32'd0);

    // Reset mid-frame, then non-sync samples ignored
    step(1, 1, 2'd1);
    step(1, 0, 2'd2);
    do_reset(1);
    check_outs("rst_mid_outs", 8'h00);
    check("rst_mid_locked", {31'd0, locked}, 32'd0);
    check("rst_mid_chan", {30'd0, chan}, 32'd0);
    for (int k = 0; k < 4; k++) step(1, 0, 2'(k));
    check("post_rst_locked", {31'd0, locked}, 32'd0);
    check("post_rst_chan", {30'd0, chan}, 32'd0);
    check("post_rst_fv_cnt", fv_cnt, 32'd0);
    check_outs("post_rst_outs", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
